// File: rtl/uart_pkg.sv
// Shared definitions for the frame-buffer UART link (TX controller and RX assembler).
package uart_pkg;
  localparam int PIXEL_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [3:0] {
    IDLE, READ, LATCH,
    SEND_R, WAITH_R, WAITL_R,
    SEND_G, WAITH_G, WAITL_G,
    SEND_B, WAITH_B, WAITL_B,
    NEXT
  } tx_state_t;

  function automatic uart_byte_t pixel_lane(input logic [PIXEL_W-1:0] px, input int lsb);
    return px[lsb +: 8];
  endfunction
endpackage

// File: rtl/pixel_addr_counter.sv
// Pixel read-address counter: clears to 0, steps by one, saturates at N_PIXELS-1.
module pixel_addr_counter #(
  parameter int N_PIXELS = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIXELS - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (inc && (addr != LAST)) begin
      addr <= addr + 1'b1;
    end
  end

  assign is_last = (addr == LAST);
endmodule

// File: rtl/uart_tx_ctrl.sv
// Streams BRAM pixels as R,G,B UART bytes; FSM state is exported on state_dbg.
// Handshake: tx_start is a one-cycle request; the TX core answers with a tx_busy
// pulse (any width, any delay) and the next byte is issued only after it falls.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int N_PIXELS = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       bram_data,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done,
  output tx_state_t         state_dbg
);
  tx_state_t            state;
  logic [PIXEL_W-1:0]   pixel;
  logic                 is_last;
  logic                 addr_clear;
  logic                 addr_inc;

  // The address only moves while in NEXT, so it is stable for READ of every pixel.
  assign addr_clear = (state == IDLE) || ((state == NEXT) && is_last);
  assign addr_inc   = (state == NEXT) && !is_last;
  assign state_dbg  = state;

  pixel_addr_counter #(
    .N_PIXELS (N_PIXELS),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .clk     (clk),
    .reset   (reset),
    .clear   (addr_clear),
    .inc     (addr_inc),
    .addr    (bram_addr),
    .is_last (is_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pixel      <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      bram_rd_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      bram_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= READ;
            bram_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          // BRAM word is valid this cycle; R goes straight out alongside the capture.
          pixel    <= bram_data;
          tx_data  <= pixel_lane(bram_data, R_LSB);
          tx_start <= 1'b1;
          state    <= SEND_R;
        end
        SEND_R:  state <= WAITH_R;
        WAITH_R: if (tx_busy) state <= WAITL_R;
        WAITL_R: begin
          if (!tx_busy) begin
            tx_data  <= pixel_lane(pixel, G_LSB);
            tx_start <= 1'b1;
            state    <= SEND_G;
          end
        end
        SEND_G:  state <= WAITH_G;
        WAITH_G: if (tx_busy) state <= WAITL_G;
        WAITL_G: begin
          if (!tx_busy) begin
            tx_data  <= pixel_lane(pixel, B_LSB);
            tx_start <= 1'b1;
            state    <= SEND_B;
          end
        end
        SEND_B:  state <= WAITH_B;
        WAITH_B: if (tx_busy) state <= WAITL_B;
        WAITL_B: begin
          if (!tx_busy) begin
            state <= NEXT;
            done  <= is_last;
          end
        end
        NEXT: begin
          if (is_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= READ;
            bram_rd_en <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
